// File: rtl/fifo_rd_pkg.sv
// Shared widths, parameter limits and checker state encoding for the FIFO read-stream block.
package fifo_rd_pkg;

    localparam int unsigned DWIDTH_DEF = 20;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;
    localparam int unsigned ERR_CNT_W  = 16;
    localparam int unsigned WORD_CNT_W = 32;

    typedef enum logic [1:0] {
        CHK_OFF  = 2'd0,
        CHK_SEED = 2'd1,
        CHK_RUN  = 2'd2
    } chk_state_e;

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular output buffer: FIFO-ordered storage with registered occupancy.
module fifo_rd_skid_buf #(
    parameter int unsigned DWIDTH    = 20,
    parameter int unsigned BUF_DEPTH = 3,
    localparam int unsigned PtrW     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int unsigned OccW     = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DWIDTH-1:0] push_data_i,
    input  logic              pop_i,
    output logic [OccW-1:0]   occ_o,
    output logic [DWIDTH-1:0] head_o
);

    logic [DWIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]   occ_q, occ_d;
    logic              do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BUF_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        do_pop   = pop_i && (occ_q != '0);
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q;
        if (push_i && !do_pop) begin
            occ_d = occ_q + OccW'(1);
        end else if (!push_i && do_pop) begin
            occ_d = occ_q - OccW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

    // Upstream credit accounting must never push into a full buffer.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        (occ_q != OccW'(BUF_DEPTH)) || !push_i || do_pop);

endmodule

// File: rtl/fifo_rd_stream.sv
// Converts a fixed-latency FIFO read port into a valid/ready stream, with a word counter
// and an incrementing-sequence checker on the accepted words.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DWIDTH     = DWIDTH_DEF,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = 3
) (
    input  logic                  RCLOCK,
    input  logic                  RRESET,
    input  logic                  EMPTY,
    input  logic [DWIDTH-1:0]     Q,
    input  logic                  UNDERFLOW,
    output logic                  RE,
    output logic [DWIDTH-1:0]     OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    input  logic                  CHK_EN,
    input  logic                  ERR_CLR,
    output logic                  ERR,
    output logic [ERR_CNT_W-1:0]  ERR_CNT,
    output logic [WORD_CNT_W-1:0] WORD_CNT,
    output logic                  UFLOW_STICKY
);

    localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned CrdW = $clog2(BUF_DEPTH + RD_LATENCY + 1);

    if ((RD_LATENCY < RD_LAT_MIN) || (RD_LATENCY > RD_LAT_MAX)) begin : g_bad_latency
        $error("RD_LATENCY must be 1 or 2");
    end
    if (BUF_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
        $error("BUF_DEPTH must be at least RD_LATENCY+2");
    end

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [OccW-1:0]       occ;
    logic [CrdW-1:0]       inflight, credit_used;
    logic                  push, pop;

    chk_state_e            state_q, state_d;
    logic [DWIDTH-1:0]     ref_q, ref_d, ref_inc;
    logic                  mismatch;
    logic                  err_q, err_d;
    logic                  uflow_q, uflow_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;

    // Credit = buffered words plus reads still in the latency pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + CrdW'(vld_q[i]);
        end
        credit_used = CrdW'(occ) + inflight;
        RE          = !RRESET && !EMPTY && (credit_used < CrdW'(BUF_DEPTH));
        vld_d       = '0;
        vld_d[0]    = RE;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        push      = vld_q[RD_LATENCY-1];
        OUT_VALID = !RRESET && (occ != '0);
        pop       = OUT_VALID && OUT_READY;
    end

    fifo_rd_skid_buf #(
        .DWIDTH    (DWIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i       (RCLOCK),
        .rst_i       (RRESET),
        .push_i      (push),
        .push_data_i (Q),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (OUT_DATA)
    );

    always_comb begin
        state_d  = state_q;
        ref_d    = ref_q;
        mismatch = 1'b0;
        ref_inc  = ref_q + DWIDTH'(1);
        unique case (state_q)
            CHK_OFF: begin
                if (CHK_EN) state_d = CHK_SEED;
            end
            CHK_SEED: begin
                if (pop) begin
                    ref_d   = OUT_DATA;
                    state_d = CHK_RUN;
                end
            end
            CHK_RUN: begin
                if (pop) begin
                    mismatch = (OUT_DATA != ref_inc);
                    ref_d    = OUT_DATA;
                end
            end
            default: state_d = CHK_OFF;
        endcase
        if (!CHK_EN) begin
            state_d  = CHK_OFF;
            ref_d    = ref_q;
            mismatch = 1'b0;
        end

        // A new event in the same cycle as a clear wins over the clear.
        err_d     = mismatch ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
        uflow_d   = UNDERFLOW ? 1'b1 : (ERR_CLR ? 1'b0 : uflow_q);
        err_cnt_d = err_cnt_q;
        if (ERR_CLR) begin
            err_cnt_d = mismatch ? ERR_CNT_W'(1) : '0;
        end else if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
        word_cnt_d = word_cnt_q + WORD_CNT_W'(pop);
    end

    always_ff @(posedge RCLOCK) begin
        if (RRESET) begin
            vld_q      <= '0;
            state_q    <= CHK_OFF;
            ref_q      <= '0;
            err_q      <= 1'b0;
            uflow_q    <= 1'b0;
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            vld_q      <= vld_d;
            state_q    <= state_d;
            ref_q      <= ref_d;
            err_q      <= err_d;
            uflow_q    <= uflow_d;
            err_cnt_q  <= err_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign ERR          = err_q;
    assign ERR_CNT      = err_cnt_q;
    assign WORD_CNT     = word_cnt_q;
    assign UFLOW_STICKY = uflow_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a FIFO model feeds the DUT, a stream-level model checks every cycle.
module tb_fifo_rd_stream;

    localparam int unsigned DW    = 20;
    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          RRESET, EMPTY, UNDERFLOW, RE, OUT_VALID, OUT_READY;
    logic          CHK_EN, ERR_CLR, ERR, UFLOW_STICKY;
    logic [DW-1:0] Q, OUT_DATA;
    logic [15:0]   ERR_CNT;
    logic [31:0]   WORD_CNT;

    fifo_rd_stream #(
        .DWIDTH     (DW),
        .RD_LATENCY (LAT),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .RCLOCK       (clk),
        .RRESET       (RRESET),
        .EMPTY        (EMPTY),
        .Q            (Q),
        .UNDERFLOW    (UNDERFLOW),
        .RE           (RE),
        .OUT_DATA     (OUT_DATA),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .CHK_EN       (CHK_EN),
        .ERR_CLR      (ERR_CLR),
        .ERR          (ERR),
        .ERR_CNT      (ERR_CNT),
        .WORD_CNT     (WORD_CNT),
        .UFLOW_STICKY (UFLOW_STICKY)
    );

    // Source FIFO: one-cycle read latency, emptied by the shared reset.
    logic [DW-1:0] mem [128];
    logic [6:0]    wr_cnt = '0;
    logic [6:0]    rd_idx = '0;
    logic [DW-1:0] q_r    = '0;
    assign EMPTY = (rd_idx >= wr_cnt);
    assign Q     = q_r;

    always @(posedge clk) begin
        if (RRESET) begin
            rd_idx <= wr_cnt;
        end else if (RE && !EMPTY) begin
            q_r    <= mem[rd_idx];
            rd_idx <= rd_idx + 7'd1;
        end
    end

    // Stream model: each read yields one word, visible LAT+1 cycles later, in order.
    typedef struct {
        logic [DW-1:0] data;
        int            avail;
    } ent_t;

    ent_t          exp_q[$];
    int            cyc = 0;
    bit            model_ok = 1'b0;
    bit            armed = 1'b0;
    bit            have_ref = 1'b0;
    logic [DW-1:0] ref_m = '0;
    bit            m_err = 1'b0;
    bit            m_uflow = 1'b0;
    logic [15:0]   m_err_cnt = '0;
    logic [31:0]   m_word_cnt = '0;
    int            n_chk = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit            exp_valid, exp_re, pop, err_set;
        logic [DW-1:0] pop_data, nxt;
        @(negedge clk);
        exp_valid = !RRESET && (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
        exp_re    = !RRESET && !EMPTY && (exp_q.size() < int'(DEPTH));
        chk("re", 32'(RE), 32'(exp_re));
        chk("out_valid", 32'(OUT_VALID), 32'(exp_valid));
        if (exp_valid) chk("out_data", 32'(OUT_DATA), 32'(exp_q[0].data));
        if (model_ok) begin
            chk("err", 32'(ERR), 32'(m_err));
            chk("err_cnt", 32'(ERR_CNT), 32'(m_err_cnt));
            chk("word_cnt", WORD_CNT, m_word_cnt);
            chk("uflow_sticky", 32'(UFLOW_STICKY), 32'(m_uflow));
        end
        if (RRESET) begin
            exp_q.delete();
            armed      = 1'b0;
            have_ref   = 1'b0;
            m_err      = 1'b0;
            m_uflow    = 1'b0;
            m_err_cnt  = '0;
            m_word_cnt = '0;
            model_ok   = 1'b1;
        end else begin
            pop      = exp_valid && OUT_READY;
            pop_data = exp_valid ? exp_q[0].data : '0;
            err_set  = 1'b0;
            if (!CHK_EN) begin
                armed    = 1'b0;
                have_ref = 1'b0;
            end else if (!armed) begin
                armed = 1'b1;
            end else if (pop) begin
                nxt = ref_m + 20'd1;
                if (have_ref && (pop_data != nxt)) err_set = 1'b1;
                ref_m    = pop_data;
                have_ref = 1'b1;
            end
            if (err_set) m_err = 1'b1;
            else if (ERR_CLR) m_err = 1'b0;
            if (ERR_CLR) m_err_cnt = err_set ? 16'd1 : 16'd0;
            else if (err_set && (m_err_cnt != 16'hFFFF)) m_err_cnt = m_err_cnt + 16'd1;
            if (UNDERFLOW) m_uflow = 1'b1;
            else if (ERR_CLR) m_uflow = 1'b0;
            if (pop) begin
                m_word_cnt = m_word_cnt + 32'd1;
                void'(exp_q.pop_front());
            end
            if (exp_re) exp_q.push_back('{mem[rd_idx], cyc + int'(LAT) + 1});
        end
        cyc++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        mem[wr_cnt] = w;
        wr_cnt      = wr_cnt + 7'd1;
    endtask

    initial begin
        RRESET    = 1'b1;
        UNDERFLOW = 1'b0;
        OUT_READY = 1'b1;
        CHK_EN    = 1'b0;
        ERR_CLR   = 1'b0;
        @(posedge clk);
        #1;
        tick(2);
        RRESET = 1'b0;
        chk("rst_word_cnt", WORD_CNT, 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);

        // In-order stream 0..9 with a two-cycle first-word latency.
        CHK_EN = 1'b1;
        for (int i = 0; i < 10; i++) load(DW'(i));
        tick(1);
        chk("lat_not_yet", 32'(OUT_VALID), 32'd0);
        tick(1);
        chk("lat_valid", 32'(OUT_VALID), 32'd1);
        chk("lat_first", 32'(OUT_DATA), 32'd0);
        tick(12);
        chk("stream_word_cnt", WORD_CNT, 32'd10);
        chk("stream_err", 32'(ERR), 32'd0);

        // Backpressure for five cycles mid-stream.
        for (int i = 10; i < 30; i++) load(DW'(i));
        tick(4);
        OUT_READY = 1'b0;
        tick(3);
        chk("bp_re_stop", 32'(RE), 32'd0);
        chk("bp_hold_data", 32'(OUT_DATA), 32'd12);
        tick(2);
        OUT_READY = 1'b1;
        tick(25);
        chk("bp_word_cnt", WORD_CNT, 32'd30);
        chk("bp_err", 32'(ERR), 32'd0);

        // Sequence error: 5,6,8,9.
        CHK_EN = 1'b0;
        tick(1);
        CHK_EN = 1'b1;
        tick(1);
        load(20'd5); load(20'd6); load(20'd8); load(20'd9);
        tick(4);
        chk("seq_before_8", 32'(ERR), 32'd0);
        tick(1);
        chk("seq_err", 32'(ERR), 32'd1);
        chk("seq_err_cnt", 32'(ERR_CNT), 32'd1);
        tick(3);
        chk("seq_no_new_err", 32'(ERR_CNT), 32'd1);
        chk("seq_word_cnt", WORD_CNT, 32'd34);
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        chk("clr_err", 32'(ERR), 32'd0);
        chk("clr_err_cnt", 32'(ERR_CNT), 32'd0);

        // Wrap of the sequence at 2^DW.
        CHK_EN = 1'b0;
        tick(1);
        CHK_EN = 1'b1;
        tick(1);
        load(20'hFFFFE); load(20'hFFFFF); load(20'h00000);
        tick(8);
        chk("wrap_err", 32'(ERR), 32'd0);
        chk("wrap_word_cnt", WORD_CNT, 32'd37);

        // Reset with a read in flight.
        CHK_EN = 1'b0;
        tick(1);
        CHK_EN = 1'b1;
        tick(1);
        for (int i = 100; i < 110; i++) load(DW'(i));
        tick(4);
        RRESET = 1'b1;
        #1;
        chk("rst_cycle_re", 32'(RE), 32'd0);
        chk("rst_cycle_valid", 32'(OUT_VALID), 32'd0);
        tick(1);
        RRESET = 1'b0;
        chk("mid_rst_word_cnt", WORD_CNT, 32'd0);
        chk("mid_rst_err_cnt", 32'(ERR_CNT), 32'd0);
        tick(3);
        chk("late_word_dropped", 32'(OUT_VALID), 32'd0);

        // Clear racing a mismatch and an underflow.
        load(20'd1); load(20'd3);
        tick(6);
        chk("race_pre_err_cnt", 32'(ERR_CNT), 32'd1);
        UNDERFLOW = 1'b1;
        tick(1);
        UNDERFLOW = 1'b0;
        chk("uflow_set", 32'(UFLOW_STICKY), 32'd1);
        OUT_READY = 1'b0;
        load(20'd4); load(20'd9);
        tick(4);
        OUT_READY = 1'b1;
        tick(1);
        ERR_CLR   = 1'b1;
        UNDERFLOW = 1'b1;
        tick(1);
        ERR_CLR   = 1'b0;
        UNDERFLOW = 1'b0;
        chk("race_err", 32'(ERR), 32'd1);
        chk("race_err_cnt", 32'(ERR_CNT), 32'd1);
        chk("race_uflow", 32'(UFLOW_STICKY), 32'd1);
        chk("race_word_cnt", WORD_CNT, 32'd4);
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        chk("final_clr_err", 32'(ERR), 32'd0);
        chk("final_clr_cnt", 32'(ERR_CNT), 32'd0);
        chk("final_clr_uflow", 32'(UFLOW_STICKY), 32'd0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DWIDTH, default 20: FIFO read-data and output-stream width.
REQ-002 Parameter RD_LATENCY, default 1: cycles from FIFO read-enable to valid FIFO read data; legal values are 1 and 2.
REQ-003 Parameter BUF_DEPTH, default 3: output buffer entries; must be at least RD_LATENCY+2, and elaboration fails otherwise.
REQ-004 One clock and one synchronous, active-high reset; all logic is on RCLOCK.
REQ-005 Port RCLOCK, in, 1: read-domain clock.
REQ-006 Port RRESET, in, 1: synchronous reset, active-high.
REQ-007 Port EMPTY, in, 1: FIFO empty flag.
REQ-008 Port Q, in, DWIDTH: FIFO read data.
REQ-009 Port UNDERFLOW, in, 1: FIFO underflow flag.
REQ-010 Port RE, out, 1: FIFO read enable, active-high.
REQ-011 Port OUT_DATA, out, DWIDTH: stream data.
REQ-012 Port OUT_VALID, out, 1: stream valid.
REQ-013 Port OUT_READY, in, 1: stream ready.
REQ-014 Port CHK_EN, in, 1: enables the sequence checker.
REQ-015 Port ERR_CLR, in, 1: single-cycle clear of ERR, ERR_CNT and UFLOW_STICKY.
REQ-016 Port ERR, out, 1: sticky sequence-error flag.
REQ-017 Port ERR_CNT, out, 16: saturating count of sequence errors.
REQ-018 Port WORD_CNT, out, 32: wrapping count of accepted stream words.
REQ-019 Port UFLOW_STICKY, out, 1: sticky capture of UNDERFLOW.

Function
REQ-020 RE SHALL be asserted, combinationally, exactly when EMPTY==0 and (occ + inflight) < BUF_DEPTH, where occ is the registered buffer occupancy and inflight is the number of reads issued but not yet returned.
REQ-021 The read path SHALL use a RD_LATENCY-deep valid shift register; Q SHALL be written into the buffer in the cycle where the shift-register output is 1, with no other qualification.
REQ-022 The output buffer SHALL be first-in first-out; OUT_VALID = (occ != 0); OUT_DATA = head entry; a word is popped when OUT_VALID && OUT_READY.
REQ-023 A simultaneous push and pop SHALL leave occ unchanged; with BUF_DEPTH 3, RD_LATENCY 1, EMPTY 0 and OUT_READY 1, throughput SHALL be one word per cycle.
REQ-024 The buffer SHALL never overflow: the RE condition guarantees space, and the assertion occ <= BUF_DEPTH always holds.
REQ-025 OUT_DATA/OUT_VALID SHALL hold stable while OUT_VALID && !OUT_READY.
REQ-026 Latency SHALL be RD_LATENCY+1 cycles from RE assertion to first OUT_VALID when the buffer is empty.
REQ-027 WORD_CNT SHALL increment by 1 per pop and wrap from 0xFFFFFFFF to 0.
REQ-028 The checker SHALL be an FSM with states CHK_OFF, CHK_SEED and CHK_RUN.
REQ-029 The checker SHALL move from CHK_OFF to CHK_SEED when CHK_EN==1.
REQ-030 In CHK_SEED, the first pop SHALL store OUT_DATA as the expected reference, without an error check, and move to CHK_RUN.
REQ-031 In CHK_RUN, each pop SHALL compare OUT_DATA to (ref+1) mod 2^DWIDTH; on mismatch, set ERR, increment ERR_CNT (saturating at 0xFFFF) and re-seed ref from OUT_DATA; on match, ref = OUT_DATA.
REQ-032 The checker SHALL go from any state to CHK_OFF when CHK_EN==0; a later CHK_EN=1 re-seeds.
REQ-033 ERR_CLR SHALL clear ERR, ERR_CNT and UFLOW_STICKY; if an error or UNDERFLOW coincides with ERR_CLR, the set wins, leaving ERR=1, ERR_CNT=1 and UFLOW_STICKY=1.
REQ-034 UFLOW_STICKY SHALL set on any cycle with UNDERFLOW==1.

Reset
REQ-035 When RRESET==1, occ, inflight, the valid shift register, ERR, ERR_CNT, WORD_CNT and UFLOW_STICKY SHALL be 0 and the FSM SHALL be in CHK_OFF.
REQ-036 RE and OUT_VALID SHALL be 0 during the reset cycle, regardless of EMPTY.
REQ-037 Read data returning after reset from reads issued before it SHALL be discarded.
REQ-038 The FIFO's own reset is controlled externally; the system integration guarantees that the FIFO and this block are reset together.

Structure
REQ-039 Package fifo_rd_pkg SHALL hold the DWIDTH default, the RD_LATENCY legal range, ERR_CNT_W=16, WORD_CNT_W=32 and the checker-state enumeration.
REQ-040 The output buffer SHALL be the sub-module fifo_rd_skid_buf, parameterised by DWIDTH and BUF_DEPTH, with push/pop/occ ports.
REQ-041 The RE/credit logic and the checker SHALL be in the top module.

Verification
REQ-042 Stream: preload 0..9, EMPTY toggling per the FIFO model, OUT_READY=1, CHK_EN=1 -> OUT_DATA 0..9 in order at one word per cycle after a 2-cycle latency; WORD_CNT=10; ERR=0.
REQ-043 Backpressure: OUT_READY=0 for 5 cycles mid-stream -> RE stops with occ+inflight=3, no data lost or duplicated, OUT_DATA held stable.
REQ-044 Sequence error: words 5,6,8,9 -> ERR=1 and ERR_CNT=1 after the word 8; word 9 raises no new error.
REQ-045 Wrap: words 0xFFFFE, 0xFFFFF, 0x00000 -> ERR=0.
REQ-046 Reset mid-stream: RRESET pulse with a read in flight -> the late word is dropped, all counters are 0, and the FSM is in CHK_OFF.
REQ-047 Clear race: ERR_CLR in the same cycle as a mismatch, plus UNDERFLOW pulsed -> ERR=1, ERR_CNT=1, UFLOW_STICKY=1.
